pipeline_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage pipeline. It combines the load-use stall request from hazard detection with the other stall sources: taken-branch redirect, data-memory wait, multi-cycle mul/div occupancy and WFI sleep. From these it produces per-stage register write enables, flush/bubble controls and the core clock-gate enable. It sits beside the hazard detection logic and drives every pipeline register's enable/flush pins.

---
 rtl/pipeline_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush scheduler: merges load-use, branch redirect, data-memory
// wait, multi-cycle mul/div occupancy and WFI sleep into per-stage register
// enables, flush/bubble controls and the core clock-gate enable.
module pipeline_ctrl #(
  parameter int MDIV_CYCLES  = 32,
  parameter int CNT_W        = 6,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_use_hazard,
  input  logic       branch_taken_ex,
  input  logic       ex_mdiv_start,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  input  logic       wfi_ex,
  input  logic       irq_wake,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       ex_mem_write,
  output logic       mem_wb_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_bubble,
  output logic       mdiv_busy,
  output logic       mdiv_done,
  output logic       core_clk_en,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_MDIV  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  // The start cycle itself counts toward the mul/div occupancy, so the
  // counter is loaded two short of the total and the done cycle sees zero.
  localparam logic [CNT_W-1:0] MDIV_LOAD  = CNT_W'(MDIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_stall;
  // Enables packed as {pc, if_id, id_ex, ex_mem, mem_wb}.
  logic [4:0]       wr_en;

  assign mem_stall = dmem_req & ~dmem_ready;

  // State and counter registers; reset abandons any mul/div or sleep sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and pipeline control decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_en         = 5'b11111;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mdiv_busy     = 1'b0;
    mdiv_done     = 1'b0;
    core_clk_en   = 1'b1;

    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          // Whole pipeline freezes; the other requests are held upstream.
          wr_en = 5'b00000;
        end else if (branch_taken_ex) begin
          // Redirect kills the two younger instructions; a load-use stall
          // on a killed instruction is moot.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_mdiv_start) begin
          wr_en         = 5'b00011;
          ex_mem_bubble = 1'b1;
          mdiv_busy     = 1'b1;
          cnt_d         = MDIV_LOAD;
          state_d       = ST_MDIV;
        end else if (wfi_ex) begin
          // WFI moves on to MEM; everything younger is discarded.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_d       = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else if (load_use_hazard) begin
          wr_en       = 5'b00111;
          id_ex_flush = 1'b1;
        end
      end

      ST_MDIV: begin
        mdiv_busy = 1'b1;
        // The unit keeps computing even while memory stalls the pipeline.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (mem_stall) begin
          wr_en = 5'b00000;
        end else if (cnt_q == '0) begin
          mdiv_done = 1'b1;
          state_d   = ST_RUN;
        end else begin
          wr_en         = 5'b00011;
          ex_mem_bubble = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Front end frozen on the instruction after WFI while MEM/WB empty.
        wr_en         = {3'b000, ~mem_stall, ~mem_stall};
        id_ex_flush   = 1'b1;
        ex_mem_bubble = 1'b1;
        if (!mem_stall) begin
          if (cnt_q == '0) begin
            state_d = ST_SLEEP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      ST_SLEEP: begin
        wr_en       = 5'b00000;
        core_clk_en = 1'b0;
        if (irq_wake) begin
          state_d = ST_WAKE;
        end
      end

      ST_WAKE: begin
        // One cycle with the clock running before fetch resumes.
        wr_en   = 5'b00000;
        state_d = ST_RUN;
      end

      default: begin
        wr_en   = 5'b00000;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    endcase
  end

  assign pc_write     = wr_en[4];
  assign if_id_write  = wr_en[3];
  assign id_ex_write  = wr_en[2];
  assign ex_mem_write = wr_en[1];
  assign mem_wb_write = wr_en[0];
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table vectors in RUN, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  localparam int MDIV_CYCLES  = 32;
  localparam int CNT_W        = 6;
  localparam int DRAIN_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_use_hazard, branch_taken_ex, ex_mdiv_start;
  logic       dmem_req, dmem_ready, wfi_ex, irq_wake;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic       if_id_flush, id_ex_flush, ex_mem_bubble;
  logic       mdiv_busy, mdiv_done, core_clk_en;
  logic [2:0] state_dbg;

  pipeline_ctrl #(
    .MDIV_CYCLES (MDIV_CYCLES),
    .CNT_W       (CNT_W),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_use_hazard(load_use_hazard),
    .branch_taken_ex(branch_taken_ex),
    .ex_mdiv_start  (ex_mdiv_start),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .wfi_ex         (wfi_ex),
    .irq_wake       (irq_wake),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_write    (id_ex_write),
    .ex_mem_write   (ex_mem_write),
    .mem_wb_write   (mem_wb_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_bubble  (ex_mem_bubble),
    .mdiv_busy      (mdiv_busy),
    .mdiv_done      (mdiv_done),
    .core_clk_en    (core_clk_en),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  // Output word: [13:9] enables pc..mem_wb, [8] if_id_flush, [7] id_ex_flush,
  // [6] bubble, [5] busy, [4] done, [3] core_clk_en, [2:0] state_dbg.
  logic [13:0] outs;
  assign outs = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                 if_id_flush, id_ex_flush, ex_mem_bubble, mdiv_busy, mdiv_done,
                 core_clk_en, state_dbg};

  // Input word: {load_use, branch, mdiv_start, dmem_req, dmem_ready, wfi, irq}
  localparam logic [6:0] I_IDLE  = 7'b0000000;
  localparam logic [6:0] I_LU    = 7'b1000000;
  localparam logic [6:0] I_BR    = 7'b0100000;
  localparam logic [6:0] I_MDIV  = 7'b0010000;
  localparam logic [6:0] I_STALL = 7'b0001000;
  localparam logic [6:0] I_WFI   = 7'b0000010;
  localparam logic [6:0] I_IRQ   = 7'b0000001;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  logic [13:0] last_out;

  // Behavioural model: tracks what the core is doing, not how it is encoded.
  bit m_mdiv, m_drain, m_sleep, m_wake;
  int m_age;      // cycles since the mul/div start cycle
  int m_drained;  // non-stalled drain cycles completed

  task automatic model_reset();
    m_mdiv = 0; m_drain = 0; m_sleep = 0; m_wake = 0;
    m_age = 0; m_drained = 0;
  endtask

  function automatic logic [13:0] model_out();
    logic       stall;
    logic [4:0] en;
    logic       fi, fe, bub, busy, done, cke;
    logic [2:0] st;
    stall = dmem_req & ~dmem_ready;
    en = 5'b11111; fi = 0; fe = 0; bub = 0; busy = 0; done = 0; cke = 1; st = 3'd0;
    if (m_mdiv) begin
      st = 3'd1; busy = 1;
      if (stall) en = 5'b00000;
      else if (m_age >= MDIV_CYCLES - 1) done = 1;
      else begin en = 5'b00011; bub = 1; end
    end else if (m_drain) begin
      st = 3'd2; en = {3'b000, ~stall, ~stall}; fe = 1; bub = 1;
    end else if (m_sleep) begin
      st = 3'd3; en = 5'b00000; cke = 0;
    end else if (m_wake) begin
      st = 3'd4; en = 5'b00000;
    end else if (stall) begin
      en = 5'b00000;
    end else if (branch_taken_ex) begin
      fi = 1; fe = 1;
    end else if (ex_mdiv_start) begin
      en = 5'b00011; bub = 1; busy = 1;
    end else if (wfi_ex) begin
      fi = 1; fe = 1;
    end else if (load_use_hazard) begin
      en = 5'b00111; fe = 1;
    end
    return {en, fi, fe, bub, busy, done, cke, st};
  endfunction

  task automatic model_advance();
    logic stall;
    stall = dmem_req & ~dmem_ready;
    if (m_mdiv) begin
      if (!stall && m_age >= MDIV_CYCLES - 1) m_mdiv = 0;
      else m_age++;
    end else if (m_drain) begin
      if (!stall) begin
        if (m_drained + 1 >= DRAIN_CYCLES) begin m_drain = 0; m_sleep = 1; end
        else m_drained++;
      end
    end else if (m_sleep) begin
      if (irq_wake) begin m_sleep = 0; m_wake = 1; end
    end else if (m_wake) begin
      m_wake = 0;
    end else if (!stall && !branch_taken_ex) begin
      if (ex_mdiv_start) begin m_mdiv = 1; m_age = 1; end
      else if (wfi_ex) begin m_drain = 1; m_drained = 0; end
    end
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {load_use_hazard, branch_taken_ex, ex_mdiv_start, dmem_req, dmem_ready, wfi_ex, irq_wake} = v;
  endtask

  // One clock cycle: drive after the edge, compare mid-cycle, advance model.
  task automatic cyc(input logic [6:0] v, input string name);
    logic [13:0] want;
    @(posedge clk); #1;
    drive(v);
    #3;
    cyc_no++;
    want = model_out();
    last_out = outs;
    $display("cyc %0d %s in=%b out=%b exp=%b", cyc_no, name, v, outs, want);
    check(name, outs, want);
    model_advance();
  endtask

  // Table vector in RUN: compared against the constant in the table.
  task automatic apply_vec(input logic [6:0] v, input logic [13:0] want, input string name);
    @(posedge clk); #1;
    drive(v);
    #3;
    cyc_no++;
    $display("vec %s in=%b out=%b exp=%b", name, v, outs, want);
    check(name, outs, want);
    model_advance();
  endtask

  typedef struct {
    logic [6:0]  in;
    logic [13:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int done_at, busy_cnt, sleep_at, done_seen;
    logic [6:0] rv;

    vecs[0] = '{I_IDLE,             14'b11111_000_00_1_000, "idle"};
    vecs[1] = '{I_LU,               14'b00111_010_00_1_000, "load_use"};
    vecs[2] = '{I_LU | I_BR,        14'b11111_110_00_1_000, "lu_branch"};
    vecs[3] = '{I_BR,               14'b11111_110_00_1_000, "branch"};
    vecs[4] = '{I_STALL,            14'b00000_000_00_1_000, "mem_stall"};
    vecs[5] = '{I_STALL|I_BR|I_LU,  14'b00000_000_00_1_000, "stall_prio"};
    vecs[6] = '{7'b0001100,         14'b11111_000_00_1_000, "req_ready"};
    vecs[7] = '{I_IRQ,              14'b11111_000_00_1_000, "irq_in_run"};
    vecs[8] = '{I_LU,               14'b00111_010_00_1_000, "load_use2"};

    rst_n = 1'b0;
    drive(I_IDLE);
    model_reset();
    last_out = '0;
    #3;
    check("reset_outs", outs, 14'b11111_000_00_1_000);
    #9 rst_n = 1'b1;

    // Table vectors, with an idle cycle between each to show single-cycle effect.
    for (int i = 0; i < 9; i++) begin
      apply_vec(vecs[i].in, vecs[i].exp, vecs[i].name);
      apply_vec(I_IDLE, 14'b11111_000_00_1_000, "after_vec");
    end

    // Mul/div occupancy: busy for MDIV_CYCLES cycles, done on the last.
    done_at = -1; busy_cnt = 0;
    cyc(I_MDIV, "mdiv_start");
    if (last_out[5]) busy_cnt++;
    for (int k = 2; k <= 40; k++) begin
      cyc(I_IDLE, "mdiv_run");
      if (last_out[5] && done_at < 0) busy_cnt++;
      if (last_out[4] && done_at < 0) done_at = k;
    end
    check_int("mdiv_done_cycle", done_at, MDIV_CYCLES);
    check_int("mdiv_busy_cycles", busy_cnt, MDIV_CYCLES);

    // Mul/div with memory stall across the finish: done waits for ready.
    done_at = -1;
    cyc(I_MDIV, "mdiv2_start");
    for (int k = 2; k <= 60; k++) begin
      cyc((k >= 30 && k <= 40) ? I_STALL : I_IDLE, "mdiv2_run");
      if (last_out[4] && done_at < 0) done_at = k;
    end
    check_int("mdiv_stall_done_cycle", done_at, 41);

    // WFI: flush cycle, DRAIN_CYCLES drain cycles, then sleep until irq.
    sleep_at = -1;
    cyc(I_WFI, "wfi");
    for (int k = 2; k <= 8; k++) begin
      cyc(I_IDLE, "wfi_drain");
      if (!last_out[3] && sleep_at < 0) sleep_at = k;
    end
    check_int("sleep_cycle", sleep_at, 2 + DRAIN_CYCLES);
    cyc(I_IRQ, "irq");
    cyc(I_IDLE, "wake");
    check_int("wake_state", int'(last_out[2:0]), 4);
    cyc(I_IDLE, "resume");
    check_int("resume_state", int'(last_out[2:0]), 0);

    // Asynchronous reset while the mul/div counter sits at 10.
    cyc(I_MDIV, "mdiv3_start");
    for (int k = 1; k <= 21; k++) cyc(I_IDLE, "mdiv3_run");
    #2 rst_n = 1'b0;
    #1;
    check_int("async_rst_state", int'(state_dbg), 0);
    check_int("async_rst_busy", int'(mdiv_busy), 0);
    model_reset();
    #1 rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(I_IDLE, "post_rst");
      if (last_out[4]) done_seen++;
    end
    check_int("no_done_after_rst", done_seen, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rv[6] = ($urandom_range(0, 99) < 30);
      rv[5] = ($urandom_range(0, 99) < 15);
      rv[4] = ($urandom_range(0, 99) < 5);
      rv[3] = ($urandom_range(0, 99) < 30);
      rv[2] = ($urandom_range(0, 99) < 60);
      rv[1] = ($urandom_range(0, 99) < 4);
      rv[0] = ($urandom_range(0, 99) < 20);
      cyc(rv, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
